// File: rtl/i2c_time_slave.sv
// i2c_time_slave: write-only I2C slave that loads a BCD hh:mm value into the clock or alarm.
// Transaction: address, pointer (0 clock / 1 alarm), hours, minutes; the load is committed on STOP.
module i2c_time_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h42,
  parameter int SYNC_STAGES = 2
) (
  input  logic       sysclk,
  input  logic       rst_n,
  input  logic       scl,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [3:0] hour_t,
  output logic [3:0] hour_o,
  output logic [3:0] min_t,
  output logic [3:0] min_o,
  output logic       ld_clk,
  output logic       ld_alm,
  output logic       busy
);
  typedef enum logic [3:0] {IDLE, ADDR, ACK_A, PTR, ACK_P, HRS, ACK_H, MINS, ACK_M, IGNORE} stateT;
  localparam logic [2:0] SETTLE = 3'(SYNC_STAGES + 1);
  stateT state, nextState;
  logic [SYNC_STAGES-1:0] sclSync, sdaSync;
  logic sclS, sdaS, sclD, sdaD, ready;
  logic sclRise, sclFall, startDet, stopDet;
  logic [2:0] settle;
  logic [3:0] bitCnt;
  logic [7:0] shiftReg, hrsReg, minReg;
  logic ptrSel, pendLoad, isData, isAck, byteOk, byteDone, hrsOk, minOk;

  assign sclS = sclSync[SYNC_STAGES-1];
  assign sdaS = sdaSync[SYNC_STAGES-1];
  // edges are masked until the synchronizer has refilled after reset, so a busy bus cannot fake a START
  assign ready = settle == SETTLE;
  assign sclRise = ready & sclS & ~sclD;
  assign sclFall = ready & ~sclS & sclD;
  assign startDet = ready & sclS & sclD & sdaD & ~sdaS;
  assign stopDet = ready & sclS & sclD & ~sdaD & sdaS;
  assign isData = state inside {ADDR, PTR, HRS, MINS};
  assign isAck = state inside {ACK_A, ACK_P, ACK_H, ACK_M};
  assign byteDone = sclFall & isData & (bitCnt == 4'd8);
  assign hrsOk = shiftReg[7:4] <= 4'd2 && shiftReg[3:0] <= 4'd9 && shiftReg <= 8'h23;
  assign minOk = shiftReg[7:4] <= 4'd5 && shiftReg[3:0] <= 4'd9;
  assign byteOk = state == ADDR ? (shiftReg[7:1] == SLAVE_ADDR && !shiftReg[0]) :
                  state == PTR  ? shiftReg[7:1] == 7'd0 :
                  state == HRS  ? hrsOk : minOk;

  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      sclSync <= '1;
      sdaSync <= '1;
      sclD <= 1'b1;
      sdaD <= 1'b1;
      settle <= '0;
    end else begin
      sclSync <= {sclSync[SYNC_STAGES-2:0], scl};
      sdaSync <= {sdaSync[SYNC_STAGES-2:0], sda_in};
      sclD <= sclS;
      sdaD <= sdaS;
      settle <= settle + 3'(settle != SETTLE);
    end
  end

  always_ff @(posedge sysclk) begin
    if (!rst_n) state <= IDLE;
    else state <= nextState;
  end

  // enum order interleaves each byte state with its ACK state, so +1 walks the sequence
  always_comb begin
    nextState = state;
    if (startDet) nextState = ADDR;
    else if (stopDet) nextState = IDLE;
    else if (sclFall && isAck) nextState = stateT'(state + 4'd1);
    else if (byteDone) nextState = byteOk ? stateT'(state + 4'd1) : IGNORE;
  end

  always_comb begin
    sda_oe = isAck & ~stopDet;
    busy = state != IDLE;
  end

  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      bitCnt <= '0;
      shiftReg <= '0;
      ptrSel <= 1'b0;
      hrsReg <= '0;
      minReg <= '0;
      pendLoad <= 1'b0;
      {hour_t, hour_o, min_t, min_o} <= '0;
      ld_clk <= 1'b0;
      ld_alm <= 1'b0;
    end else begin
      ld_clk <= 1'b0;
      ld_alm <= 1'b0;
      if (startDet) begin
        bitCnt <= '0;
        ptrSel <= 1'b0;
        hrsReg <= '0;
        minReg <= '0;
        pendLoad <= 1'b0;
      end else if (stopDet) begin
        if (pendLoad) begin
          {hour_t, hour_o} <= hrsReg;
          {min_t, min_o} <= minReg;
          ld_clk <= ~ptrSel;
          ld_alm <= ptrSel;
        end
        pendLoad <= 1'b0;
      end else begin
        if (sclRise && isData) begin
          shiftReg <= {shiftReg[6:0], sdaS};
          bitCnt <= bitCnt + 4'd1;
        end
        if (sclRise && isAck) bitCnt <= '0;
        if (byteDone && byteOk && state == PTR) ptrSel <= shiftReg[0];
        if (byteDone && byteOk && state == HRS) hrsReg <= shiftReg;
        if (byteDone && byteOk && state == MINS) minReg <= shiftReg;
        if (sclFall && state == ACK_M) pendLoad <= 1'b1;
      end
    end
  end
endmodule

// File: doc/i2c_time_slave.md
I2C_TIME_SLAVE -- requirements
Module: i2c_time_slave

Interface
REQ-001 SHALL provide parameter SLAVE_ADDR, default 7'h42, as the 7-bit I2C address this block answers.
REQ-002 SHALL provide parameter SYNC_STAGES, default 2, as the synchronizer depth on scl/sda_in (legal values 2..4).
REQ-003 sysclk  in  1  single system clock; all logic on its rising edge.
REQ-004 rst_n  in  1  synchronous, active-low reset, sampled on the sysclk rising edge.
REQ-005 scl  in  1  I2C clock from the bus master, asynchronous to sysclk.
REQ-006 sda_in  in  1  I2C data as seen on the bus, asynchronous to sysclk.
REQ-007 sda_oe  out  1  1 = pull SDA low (open-drain); 0 = release.
REQ-008 hour_t  out  4  hours tens digit, BCD, feeds the display/clock set path.
REQ-009 hour_o  out  4  hours ones digit, BCD.
REQ-010 min_t  out  4  minutes tens digit, BCD.
REQ-011 min_o  out  4  minutes ones digit, BCD.
REQ-012 ld_clk  out  1  one-cycle strobe: digits are a new clock time.
REQ-013 ld_alm  out  1  one-cycle strobe: digits are a new alarm time.
REQ-014 busy  out  1  high from START detection until STOP or abort returns FSM to IDLE.

Function
REQ-015 scl and sda_in SHALL pass through SYNC_STAGES flops; all edge detection uses only synchronized values.
REQ-016 START SHALL be sda falling while scl high; STOP SHALL be sda rising while scl high; both are detected one cycle after the synchronized edge.
REQ-017 Data bits SHALL be sampled on synchronized scl rising edges, MSB first; sda_oe SHALL change only on synchronized scl falling edges.
REQ-018 FSM states SHALL be IDLE, ADDR, ACK_A, PTR, ACK_P, HRS, ACK_H, MINS, ACK_M, IGNORE.
REQ-019 IDLE -> ADDR on START; START in any state (repeated start) SHALL go to ADDR and clear the bit counter and staged bytes.
REQ-020 ADDR: after 8 bits, if [7:1]==SLAVE_ADDR and bit0==0 go ACK_A, else go IGNORE (no ACK; read requests are not supported).
REQ-021 PTR byte: 8'h00 selects clock, 8'h01 selects alarm; other values SHALL be NACKed, go IGNORE.
REQ-022 HRS byte: high nibble tens, low nibble ones; SHALL be ACKed only if tens<=2, ones<=9 and value<=8'h23, else NACK and go IGNORE.
REQ-023 MINS byte: SHALL be ACKed only if tens<=5 and ones<=9, else NACK and go IGNORE.
REQ-024 ACK SHALL assert sda_oe from the scl falling edge after bit 8 to the scl falling edge after bit 9; NACK leaves sda_oe low.
REQ-025 Bytes after ACK_M SHALL be NACKed (state IGNORE); the pending load remains valid.
REQ-026 STOP in any state SHALL return FSM to IDLE and release sda_oe in the same cycle.
REQ-027 On STOP, if ACK_M completed in this transaction, hour_t/hour_o/min_t/min_o SHALL update and exactly one of ld_clk (ptr 0) or ld_alm (ptr 1) SHALL pulse for one cycle, both in the cycle after STOP detection.
REQ-028 STOP before ACK_M completes, or repeated START, SHALL discard staged bytes: no output change, no strobe.
REQ-029 Digit outputs SHALL hold their value between loads; ld_clk and ld_alm SHALL never be high together.
REQ-030 Bit counter SHALL be 4 bits, counting 0..8 per byte, and SHALL wrap to 0 after the ACK bit.

Reset
REQ-031 While rst_n==0 at a sysclk edge: FSM=IDLE, sda_oe=0, busy=0, ld_clk=ld_alm=0, hour_t=hour_o=min_t=min_o=0, synchronizer flops=1 (bus idle).
REQ-032 Reset mid-transaction SHALL abort without strobe; after release, the block SHALL ignore the bus until the next START.

Verification
REQ-033 Write 0x84,0x00,0x12,0x34 then STOP -> four ACKs, ld_clk pulses once, digits 1,2,3,4, ld_alm stays 0.
REQ-034 Write 0x84,0x01,0x07,0x05 then STOP -> ld_alm pulses once, digits 0,7,0,5; clock load absent.
REQ-035 Write 0x84,0x00,0x24 -> third byte NACKed, STOP gives no strobe, digits unchanged; repeat with minutes 0x60 -> fourth byte NACKed, no strobe.
REQ-036 Address 0x86 (wrong) or 0x85 (read) -> sda_oe never asserts, busy drops at STOP, no strobe.
REQ-037 0x84,0x00,0x12 then repeated START, 0x84,0x00,0x09,0x59, STOP -> single ld_clk, digits 0,9,5,9.
REQ-038 rst_n low for one cycle during the HRS byte -> sda_oe=0, busy=0, digits 0; following full write of 0x84,0x00,0x12,0x34 loads normally.
